// File: rtl/retire_unit.sv
// retire_unit
//
// Commit stage at the tail of the rename -> ROB path. Entries are popped from
// the ROB head in program order. Each retiring register write updates the
// retirement RAT and returns the superseded physical register to the rename
// free list. A retiring entry marked flush sends the unit into a walk. The walk
// drains the rest of the ROB and frees every speculatively allocated physical
// register. A single restore cycle then copies the retirement RAT into the
// rename RAT and redirects the front end.
//
// Head entry layout (bits above the flush PC are ignored):
//   [0]                      complete
//   [1]                      isRegWrite
//   [2]                      flush
//   [3 +: ARCH]              archDest
//   [3+ARCH +: PHYS]         physDest
//   [3+ARCH+PHYS +: 32]      flush target PC
//
// Ports:
//   CLK                       clock
//   RESET                     synchronous, active-high reset
//   fROB_empty_IN             ROB is empty
//   fROB_headData_IN          ROB head entry
//   tROB_popReq_OUT           pop the head this cycle (combinational)
//   fFreeL_full_IN            free list cannot accept a push
//   tFreeL_pushReq_OUT        free-list push, registered one cycle after the pop
//   tFreeL_pushData_OUT       physical register being freed
//   tRenRatOverwrite_OUT      one-cycle rename RAT restore strobe
//   tRenRatOverwriteData_OUT  packed retirement RAT, entry i at [i*PHYS +: PHYS]
//   tFlush_OUT                front-end / queue flush strobe
//   tFlushPC_OUT              redirect PC, valid with tFlush_OUT
//   tFreeze_OUT               front-end stall while the walk runs
//   retiredCount_OUT          retired-instruction counter
//
// Configuration macro:
//   RETIRE_PERFCNT_EN  when defined, retiredCount_OUT counts every pop made in
//                      RUN, wrapping at 2^32. When undefined it is tied to zero.

module retire_unit #(
    parameter int PHYSREGS_DEPTH = 6,
    parameter int ARCHREGS_DEPTH = 5,
    parameter int ROB_WIDTH      = 64
) (
    input  logic                                              CLK,
    input  logic                                              RESET,
    input  logic                                              fROB_empty_IN,
    input  logic [ROB_WIDTH-1:0]                              fROB_headData_IN,
    output logic                                              tROB_popReq_OUT,
    input  logic                                              fFreeL_full_IN,
    output logic                                              tFreeL_pushReq_OUT,
    output logic [PHYSREGS_DEPTH-1:0]                         tFreeL_pushData_OUT,
    output logic                                              tRenRatOverwrite_OUT,
    output logic [(1<<ARCHREGS_DEPTH)*PHYSREGS_DEPTH-1:0]     tRenRatOverwriteData_OUT,
    output logic                                              tFlush_OUT,
    output logic [31:0]                                       tFlushPC_OUT,
    output logic                                              tFreeze_OUT,
    output logic [31:0]                                       retiredCount_OUT
);

    localparam int ARCH_REGS = 1 << ARCHREGS_DEPTH;
    localparam int USED_BITS = 35 + ARCHREGS_DEPTH + PHYSREGS_DEPTH;
    localparam int PHYS_LSB  = 3 + ARCHREGS_DEPTH;
    localparam int PC_LSB    = 3 + ARCHREGS_DEPTH + PHYSREGS_DEPTH;

    typedef enum logic [1:0] {
        RUN,
        WALK,
        RESTORE
    } retireState_t;

    retireState_t state;
    retireState_t nextState;

    logic                      headComplete;
    logic                      headRegWrite;
    logic                      headFlush;
    logic [ARCHREGS_DEPTH-1:0] headArchDest;
    logic [PHYSREGS_DEPTH-1:0] headPhysDest;
    logic [31:0]               headPc;
    logic                      unusedHeadBits;

    logic [PHYSREGS_DEPTH-1:0] retRat [ARCH_REGS];
    logic [31:0]               latchedPc;
    logic                      popReq;

    // Field extraction from the ROB head entry.
    assign headComplete   = fROB_headData_IN[0];
    assign headRegWrite   = fROB_headData_IN[1];
    assign headFlush      = fROB_headData_IN[2];
    assign headArchDest   = fROB_headData_IN[3 +: ARCHREGS_DEPTH];
    assign headPhysDest   = fROB_headData_IN[PHYS_LSB +: PHYSREGS_DEPTH];
    assign headPc         = fROB_headData_IN[PC_LSB +: 32];
    assign unusedHeadBits = ^fROB_headData_IN[ROB_WIDTH-1:USED_BITS];

    assign tROB_popReq_OUT = popReq;

    // State register. Reset returns the unit to normal retirement from any state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and strobe decode. A full free list freezes the FSM as well
    // as the pop, because any popped register write needs a free-list slot.
    // The walk ignores the complete bit: everything behind the flushing entry
    // is wrong-path and only its register allocation matters.
    always_comb begin
        nextState            = state;
        popReq               = 1'b0;
        tFreeze_OUT          = 1'b0;
        tRenRatOverwrite_OUT = 1'b0;
        tFlush_OUT           = 1'b0;
        tFlushPC_OUT         = 32'd0;
        case (state)
            RUN: begin
                if (!fROB_empty_IN && headComplete && !fFreeL_full_IN) begin
                    popReq = 1'b1;
                    if (headFlush) begin
                        nextState = WALK;
                    end
                end
            end
            WALK: begin
                tFreeze_OUT = 1'b1;
                if (!fFreeL_full_IN) begin
                    if (fROB_empty_IN) begin
                        nextState = RESTORE;
                    end else begin
                        popReq = 1'b1;
                    end
                end
            end
            RESTORE: begin
                tRenRatOverwrite_OUT = 1'b1;
                tFlush_OUT           = 1'b1;
                tFlushPC_OUT         = latchedPc;
                nextState            = RUN;
            end
            default: begin
                nextState = RUN;
            end
        endcase
    end

    // Retirement RAT, freeing pipeline and flush PC. A retire in RUN frees the
    // mapping it supersedes. A write to arch 0 frees its own physDest because
    // arch 0 is never remapped. A walked entry frees its own physDest.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                retRat[i] <= PHYSREGS_DEPTH'(i);
            end
            tFreeL_pushReq_OUT  <= 1'b0;
            tFreeL_pushData_OUT <= '0;
            latchedPc           <= 32'd0;
        end else begin
            tFreeL_pushReq_OUT <= popReq && headRegWrite;
            if (popReq && headRegWrite) begin
                if (state == RUN && headArchDest != '0) begin
                    tFreeL_pushData_OUT <= retRat[headArchDest];
                end else begin
                    tFreeL_pushData_OUT <= headPhysDest;
                end
            end
            if (state == RUN && popReq && headRegWrite && headArchDest != '0) begin
                retRat[headArchDest] <= headPhysDest;
            end
            if (state == RUN && popReq && headFlush) begin
                latchedPc <= headPc;
            end
        end
    end

    // The packed RAT is always visible. It matters only during the restore
    // strobe, and by then any retire made before the walk is already in it.
    always_comb begin
        tRenRatOverwriteData_OUT = '0;
        for (int i = 0; i < ARCH_REGS; i++) begin
            tRenRatOverwriteData_OUT[i*PHYSREGS_DEPTH +: PHYSREGS_DEPTH] = retRat[i];
        end
    end

`ifdef RETIRE_PERFCNT_EN
    // Only real retirements are counted. Wrong-path entries popped by the
    // walk are not counted.
    logic [31:0] retiredCount;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            retiredCount <= 32'd0;
        end else if (state == RUN && popReq) begin
            retiredCount <= retiredCount + 32'd1;
        end
    end

    assign retiredCount_OUT = retiredCount;
`else
    assign retiredCount_OUT = 32'd0;
`endif

endmodule

// File: tb/tb_retire_unit.sv
// tb_retire_unit
//
// Directed testbench for retire_unit with the default parameters. Inputs
// change on the falling edge. Combinational outputs are sampled 1 ns after
// each input change. Registered outputs are sampled 1 ns after the falling
// edge that follows the clock edge that loaded them.

module tb_retire_unit;

    localparam int P        = 6;
    localparam int A        = 5;
    localparam int W        = 64;
    localparam int RAT_BITS = (1 << A) * P;

`ifdef RETIRE_PERFCNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                CLK;
    logic                RESET;
    logic                robEmpty;
    logic [W-1:0]        headData;
    logic                popReq;
    logic                freeLFull;
    logic                pushReq;
    logic [P-1:0]        pushData;
    logic                ratOverwrite;
    logic [RAT_BITS-1:0] ratData;
    logic                flush;
    logic [31:0]         flushPc;
    logic                freeze;
    logic [31:0]         retiredCount;

    int checks = 0;
    int errors = 0;

    retire_unit #(
        .PHYSREGS_DEPTH(P),
        .ARCHREGS_DEPTH(A),
        .ROB_WIDTH(W)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .fROB_empty_IN(robEmpty),
        .fROB_headData_IN(headData),
        .tROB_popReq_OUT(popReq),
        .fFreeL_full_IN(freeLFull),
        .tFreeL_pushReq_OUT(pushReq),
        .tFreeL_pushData_OUT(pushData),
        .tRenRatOverwrite_OUT(ratOverwrite),
        .tRenRatOverwriteData_OUT(ratData),
        .tFlush_OUT(flush),
        .tFlushPC_OUT(flushPc),
        .tFreeze_OUT(freeze),
        .retiredCount_OUT(retiredCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Builds a head entry. The ignored upper bits carry junk on purpose.
    function automatic logic [W-1:0] makeEntry(input logic c, input logic w, input logic f,
                                               input logic [A-1:0] a, input logic [P-1:0] p,
                                               input logic [31:0] pc);
        logic [W-1:0] e;
        e        = '0;
        e[0]     = c;
        e[1]     = w;
        e[2]     = f;
        e[7:3]   = a;
        e[13:8]  = p;
        e[45:14] = pc;
        e[63:46] = 18'h2A5A5;
        return e;
    endfunction

    function automatic logic [RAT_BITS-1:0] identityRat();
        logic [RAT_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < (1 << A); i++) begin
            r[i*P +: P] = P'(i);
        end
        return r;
    endfunction

    task automatic doReset();
        @(negedge CLK);
        RESET     = 1'b1;
        robEmpty  = 1'b1;
        headData  = '0;
        freeLFull = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        doReset();
        checks++; if (popReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_pop got %b exp 0", popReq); end
        checks++; if (pushReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_push got %b exp 0", pushReq); end
        checks++; if (pushData !== 6'd0) begin errors++; $display("[TB] FAIL reset_pushData got %0d exp 0", pushData); end
        checks++; if (ratOverwrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_overwrite got %b exp 0", ratOverwrite); end
        checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush got %b exp 0", flush); end
        checks++; if (flushPc !== 32'd0) begin errors++; $display("[TB] FAIL reset_flushPc got %h exp 0", flushPc); end
        checks++; if (freeze !== 1'b0) begin errors++; $display("[TB] FAIL reset_freeze got %b exp 0", freeze); end
        checks++; if (retiredCount !== 32'd0) begin errors++; $display("[TB] FAIL reset_count got %0d exp 0", retiredCount); end
        checks++; if (ratData !== identityRat()) begin errors++; $display("[TB] FAIL reset_rat got %h exp %h", ratData, identityRat()); end
    endtask

    task automatic test_basic_retire();
        doReset();
        headData = makeEntry(1'b1, 1'b1, 1'b0, 5'd3, 6'd40, 32'h0);
        robEmpty = 1'b0;
        #1;
        checks++; if (popReq !== 1'b1) begin errors++; $display("[TB] FAIL basic_pop got %b exp 1", popReq); end
        @(negedge CLK);
        robEmpty = 1'b1;
        #1;
        checks++; if (pushReq !== 1'b1) begin errors++; $display("[TB] FAIL basic_push got %b exp 1", pushReq); end
        checks++; if (pushData !== 6'd3) begin errors++; $display("[TB] FAIL basic_pushData got %0d exp 3", pushData); end
        checks++; if (ratData[3*P +: P] !== 6'd40) begin errors++; $display("[TB] FAIL basic_rat3 got %0d exp 40", ratData[3*P +: P]); end
        checks++; if (retiredCount !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("[TB] FAIL basic_count got %0d exp %0d", retiredCount, PERF); end
        @(negedge CLK);
        #1;
        checks++; if (pushReq !== 1'b0) begin errors++; $display("[TB] FAIL basic_push_done got %b exp 0", pushReq); end
    endtask

    task automatic test_incomplete_stall();
        doReset();
        headData = makeEntry(1'b0, 1'b1, 1'b0, 5'd5, 6'd33, 32'h0);
        robEmpty = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (popReq !== 1'b0 || pushReq !== 1'b0) begin errors++; $display("[TB] FAIL stall_cycle%0d got pop=%b push=%b exp 0/0", i, popReq, pushReq); end
            @(negedge CLK);
        end
        headData[0] = 1'b1;
        #1;
        checks++; if (popReq !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_pop got %b exp 1", popReq); end
        @(negedge CLK);
        robEmpty = 1'b1;
        #1;
        checks++; if (pushReq !== 1'b1 || pushData !== 6'd5) begin errors++; $display("[TB] FAIL stall_push got %b/%0d exp 1/5", pushReq, pushData); end
        checks++; if (retiredCount !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("[TB] FAIL stall_count got %0d exp %0d", retiredCount, PERF); end
    endtask

    task automatic test_freelist_full();
        doReset();
        headData  = makeEntry(1'b1, 1'b1, 1'b0, 5'd7, 6'd20, 32'h0);
        robEmpty  = 1'b0;
        freeLFull = 1'b1;
        #1;
        checks++; if (popReq !== 1'b0) begin errors++; $display("[TB] FAIL full_pop got %b exp 0", popReq); end
        @(negedge CLK);
        #1;
        checks++; if (pushReq !== 1'b0 || ratData[7*P +: P] !== 6'd7) begin errors++; $display("[TB] FAIL full_hold got push=%b rat7=%0d exp 0/7", pushReq, ratData[7*P +: P]); end
        freeLFull = 1'b0;
        #1;
        checks++; if (popReq !== 1'b1) begin errors++; $display("[TB] FAIL full_release_pop got %b exp 1", popReq); end
        @(negedge CLK);
        // The free list fills again right after the pop; the pending push still drains.
        freeLFull = 1'b1;
        headData  = makeEntry(1'b1, 1'b1, 1'b0, 5'd8, 6'd21, 32'h0);
        #1;
        checks++; if (pushReq !== 1'b1 || pushData !== 6'd7) begin errors++; $display("[TB] FAIL full_drain got %b/%0d exp 1/7", pushReq, pushData); end
        checks++; if (popReq !== 1'b0) begin errors++; $display("[TB] FAIL full_again_pop got %b exp 0", popReq); end
        checks++; if (ratData[7*P +: P] !== 6'd20) begin errors++; $display("[TB] FAIL full_rat7 got %0d exp 20", ratData[7*P +: P]); end
        freeLFull = 1'b0;
        robEmpty  = 1'b1;
    endtask

    task automatic test_back_to_back();
        doReset();
        headData = makeEntry(1'b1, 1'b1, 1'b0, 5'd1, 6'd60, 32'h0);
        robEmpty = 1'b0;
        @(negedge CLK);
        headData = makeEntry(1'b1, 1'b1, 1'b0, 5'd1, 6'd61, 32'h0);
        #1;
        checks++; if (popReq !== 1'b1) begin errors++; $display("[TB] FAIL b2b_pop2 got %b exp 1", popReq); end
        checks++; if (pushReq !== 1'b1 || pushData !== 6'd1) begin errors++; $display("[TB] FAIL b2b_push1 got %b/%0d exp 1/1", pushReq, pushData); end
        @(negedge CLK);
        robEmpty = 1'b1;
        #1;
        checks++; if (pushReq !== 1'b1 || pushData !== 6'd60) begin errors++; $display("[TB] FAIL b2b_push2 got %b/%0d exp 1/60", pushReq, pushData); end
        checks++; if (ratData[1*P +: P] !== 6'd61) begin errors++; $display("[TB] FAIL b2b_rat1 got %0d exp 61", ratData[1*P +: P]); end
        checks++; if (retiredCount !== (PERF ? 32'd2 : 32'd0)) begin errors++; $display("[TB] FAIL b2b_count got %0d exp %0d", retiredCount, PERF ? 2 : 0); end
    endtask

    task automatic test_flush_walk();
        doReset();
        headData = makeEntry(1'b1, 1'b1, 1'b1, 5'd4, 6'd30, 32'h400);
        robEmpty = 1'b0;
        #1;
        checks++; if (popReq !== 1'b1 || freeze !== 1'b0) begin errors++; $display("[TB] FAIL walk_flushpop got pop=%b frz=%b exp 1/0", popReq, freeze); end
        @(negedge CLK);
        headData = makeEntry(1'b0, 1'b1, 1'b0, 5'd9, 6'd50, 32'h0);
        #1;
        checks++; if (freeze !== 1'b1 || popReq !== 1'b1) begin errors++; $display("[TB] FAIL walk_c1 got frz=%b pop=%b exp 1/1", freeze, popReq); end
        checks++; if (pushReq !== 1'b1 || pushData !== 6'd4) begin errors++; $display("[TB] FAIL walk_push_old got %b/%0d exp 1/4", pushReq, pushData); end
        @(negedge CLK);
        headData = makeEntry(1'b1, 1'b1, 1'b0, 5'd10, 6'd51, 32'h0);
        #1;
        checks++; if (freeze !== 1'b1 || popReq !== 1'b1 || pushReq !== 1'b1 || pushData !== 6'd50) begin errors++; $display("[TB] FAIL walk_push50 got frz=%b pop=%b push=%b/%0d", freeze, popReq, pushReq, pushData); end
        @(negedge CLK);
        headData = makeEntry(1'b0, 1'b1, 1'b0, 5'd11, 6'd52, 32'h0);
        #1;
        checks++; if (freeze !== 1'b1 || popReq !== 1'b1 || pushReq !== 1'b1 || pushData !== 6'd51) begin errors++; $display("[TB] FAIL walk_push51 got frz=%b pop=%b push=%b/%0d", freeze, popReq, pushReq, pushData); end
        @(negedge CLK);
        robEmpty = 1'b1;
        headData = '0;
        #1;
        checks++; if (freeze !== 1'b1 || popReq !== 1'b0 || pushReq !== 1'b1 || pushData !== 6'd52) begin errors++; $display("[TB] FAIL walk_push52 got frz=%b pop=%b push=%b/%0d", freeze, popReq, pushReq, pushData); end
        checks++; if (ratOverwrite !== 1'b0) begin errors++; $display("[TB] FAIL walk_early_restore got %b exp 0", ratOverwrite); end
        @(negedge CLK);
        #1;
        checks++; if (ratOverwrite !== 1'b1 || flush !== 1'b1) begin errors++; $display("[TB] FAIL restore_strobes got ow=%b fl=%b exp 1/1", ratOverwrite, flush); end
        checks++; if (flushPc !== 32'h400) begin errors++; $display("[TB] FAIL restore_pc got %h exp 400", flushPc); end
        checks++; if (freeze !== 1'b0 || pushReq !== 1'b0) begin errors++; $display("[TB] FAIL restore_quiet got frz=%b push=%b exp 0/0", freeze, pushReq); end
        checks++; if (ratData[4*P +: P] !== 6'd30 || ratData[9*P +: P] !== 6'd9) begin errors++; $display("[TB] FAIL restore_rat got r4=%0d r9=%0d exp 30/9", ratData[4*P +: P], ratData[9*P +: P]); end
        checks++; if (retiredCount !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("[TB] FAIL walk_count got %0d exp %0d", retiredCount, PERF); end
        @(negedge CLK);
        #1;
        checks++; if (ratOverwrite !== 1'b0 || flush !== 1'b0 || flushPc !== 32'd0 || freeze !== 1'b0) begin errors++; $display("[TB] FAIL restore_end got ow=%b fl=%b pc=%h frz=%b", ratOverwrite, flush, flushPc, freeze); end
    endtask

    task automatic test_reset_mid_walk();
        doReset();
        headData = makeEntry(1'b1, 1'b1, 1'b1, 5'd6, 6'd44, 32'h800);
        robEmpty = 1'b0;
        @(negedge CLK);
        headData = makeEntry(1'b1, 1'b1, 1'b0, 5'd12, 6'd55, 32'h0);
        #1;
        checks++; if (freeze !== 1'b1) begin errors++; $display("[TB] FAIL midwalk_freeze got %b exp 1", freeze); end
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET    = 1'b0;
        robEmpty = 1'b1;
        #1;
        checks++; if (pushReq !== 1'b0 || pushData !== 6'd0) begin errors++; $display("[TB] FAIL midwalk_push got %b/%0d exp 0/0", pushReq, pushData); end
        checks++; if (freeze !== 1'b0 || ratOverwrite !== 1'b0 || flush !== 1'b0 || flushPc !== 32'd0) begin errors++; $display("[TB] FAIL midwalk_outs got frz=%b ow=%b fl=%b pc=%h", freeze, ratOverwrite, flush, flushPc); end
        checks++; if (ratData !== identityRat() || retiredCount !== 32'd0) begin errors++; $display("[TB] FAIL midwalk_rat_count got r6=%0d cnt=%0d exp 6/0", ratData[6*P +: P], retiredCount); end
        // An incomplete head is popped only by a walk, so no pop here shows the FSM is in RUN.
        headData = makeEntry(1'b0, 1'b1, 1'b0, 5'd1, 6'd2, 32'h0);
        robEmpty = 1'b0;
        #1;
        checks++; if (popReq !== 1'b0) begin errors++; $display("[TB] FAIL midwalk_run got pop=%b exp 0", popReq); end
        robEmpty = 1'b1;
    endtask

    task automatic test_arch_zero();
        doReset();
        headData = makeEntry(1'b1, 1'b1, 1'b0, 5'd0, 6'd45, 32'h0);
        robEmpty = 1'b0;
        #1;
        checks++; if (popReq !== 1'b1) begin errors++; $display("[TB] FAIL arch0_pop got %b exp 1", popReq); end
        @(negedge CLK);
        robEmpty = 1'b1;
        #1;
        checks++; if (pushReq !== 1'b1 || pushData !== 6'd45) begin errors++; $display("[TB] FAIL arch0_push got %b/%0d exp 1/45", pushReq, pushData); end
        checks++; if (ratData[0 +: P] !== 6'd0) begin errors++; $display("[TB] FAIL arch0_rat0 got %0d exp 0", ratData[0 +: P]); end
    endtask

    initial begin
        RESET     = 1'b1;
        robEmpty  = 1'b1;
        headData  = '0;
        freeLFull = 1'b0;
        test_reset();
        test_basic_retire();
        test_incomplete_stall();
        test_freelist_full();
        test_back_to_back();
        test_flush_walk();
        test_reset_mid_walk();
        test_arch_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
